// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile renderer: tile codes, 640x480@60 timing,
// 12-bit colour type and the tile palette.
// Optional build macro: TILE_GRID_EN (tile-grid debug overlay in the renderer).
package vga_pkg;

    // Tile codes carried in the background map
    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;
    localparam logic [7:0] CK1 = 8'd5;
    localparam logic [7:0] CK2 = 8'd6;

    localparam int CHARACTER_WIDTH = 42;
    localparam int BLOCK_WIDTH     = 40;
    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;

    // Horizontal timing in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter width covers both 0..799 and 0..524
    localparam int CNT_W = 10;

    // Sprite coordinate that keeps a sprite off screen
    localparam int SPRITE_OFF = 1000;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t BLACK_COLOUR  = rgb12_t'(12'h000);
    localparam rgb12_t MARIO_COLOUR  = rgb12_t'(12'hF00);
    localparam rgb12_t GOOMBA_COLOUR = rgb12_t'(12'h952);
    localparam rgb12_t GRID_COLOUR   = rgb12_t'(12'h333);

    // Palette; unknown codes show magenta so bad map data is obvious on screen
    function automatic rgb12_t tile_colour(input logic [7:0] code);
        rgb12_t colour;
        case (code)
            BDR:     colour = rgb12_t'(12'h000);
            SKY:     colour = rgb12_t'(12'h58F);
            BLK:     colour = rgb12_t'(12'h840);
            GND:     colour = rgb12_t'(12'h630);
            TKN:     colour = rgb12_t'(12'hFD0);
            CK1:     colour = rgb12_t'(12'hFFF);
            CK2:     colour = rgb12_t'(12'h000);
            default: colour = rgb12_t'(12'hF0F);
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with raw (undelayed) syncs, visible flag and
// the once-per-frame snapshot strobe at the first blanked line.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VISIBLE,
    parameter int H_FP   = H_FRONT,
    parameter int H_SW   = H_SYNC,
    parameter int H_BP   = H_BACK,
    parameter int V_VIS  = V_VISIBLE,
    parameter int V_FP   = V_FRONT,
    parameter int V_SW   = V_SYNC,
    parameter int V_BP   = V_BACK
) (
    input  logic             vga_clock,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             visible,
    output logic             snap_strobe
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VIS + H_FP + H_SW);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VIS + V_FP + V_SW);

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;

    // Pixel counter wraps each line; line counter advances on the pixel wrap
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    assign h_cnt       = h_cnt_reg;
    assign v_cnt       = v_cnt_reg;
    assign hs_raw      = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
    assign vs_raw      = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
    assign visible     = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
    assign snap_strobe = (h_cnt_reg == '0) && (v_cnt_reg == V_VIS_END);

endmodule

// File: rtl/vga_tile_renderer.sv
// Scans a 12x17 tile map plus two sprites out as VGA. Drawer inputs are
// captured once per frame at the first blanked line so the picture never tears.
// Pixel path: stage 1 = tile fetch + sprite hit, stage 2 = palette; syncs are
// delayed two cycles to stay aligned with the colour.
// Optional build macro: TILE_GRID_EN adds a grey tile-grid overlay.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VISIBLE,
    parameter int H_FP   = H_FRONT,
    parameter int H_SW   = H_SYNC,
    parameter int H_BP   = H_BACK,
    parameter int V_VIS  = V_VISIBLE,
    parameter int V_FP   = V_FRONT,
    parameter int V_SW   = V_SYNC,
    parameter int V_BP   = V_BACK
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    input  logic [11:0][16:0][7:0] background,
    input  logic signed [31:0]     mario_x,
    input  logic signed [31:0]     mario_y,
    input  logic signed [31:0]     goomba_x,
    input  logic signed [31:0]     goomba_y,
    input  logic [5:0]             scroll_px,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic             visible;
    logic             snap_strobe;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .visible     (visible),
        .snap_strobe (snap_strobe)
    );

    assign frame_start = snap_strobe;

    logic [11:0][16:0][7:0] snap_bg_reg;
    logic signed [31:0]     snap_mx_reg;
    logic signed [31:0]     snap_my_reg;
    logic signed [31:0]     snap_gx_reg;
    logic signed [31:0]     snap_gy_reg;
    logic [5:0]             snap_scroll_reg;

    // Frame snapshot of everything the drawer provides; scroll clamped to one tile
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            snap_bg_reg     <= {12{{17{BDR}}}};
            snap_mx_reg     <= SPRITE_OFF;
            snap_my_reg     <= SPRITE_OFF;
            snap_gx_reg     <= SPRITE_OFF;
            snap_gy_reg     <= SPRITE_OFF;
            snap_scroll_reg <= '0;
        end else if (snap_strobe) begin
            snap_bg_reg     <= background;
            snap_mx_reg     <= mario_x;
            snap_my_reg     <= mario_y;
            snap_gx_reg     <= goomba_x;
            snap_gy_reg     <= goomba_y;
            snap_scroll_reg <= (scroll_px > 6'd39) ? 6'd39 : scroll_px;
        end
    end

    logic [CNT_W-1:0]   h_sel;
    logic [CNT_W-1:0]   v_sel;
    logic [10:0]        wx;
    logic [4:0]         col_idx;
    logic [3:0]         row_idx;
    logic signed [31:0] h_pos;
    logic signed [31:0] v_pos;
    logic [7:0]         code_next;
    logic               mario_next;
    logic               goomba_next;

    // Stage 1 decode; blanked positions are folded onto (0,0) so map indices stay in range
    always_comb begin
        h_sel       = visible ? h_cnt : '0;
        v_sel       = visible ? v_cnt : '0;
        wx          = {1'b0, h_sel} + {5'd0, snap_scroll_reg};
        col_idx     = 5'd16 - 5'(wx / 11'd40);
        row_idx     = 4'd11 - 4'(v_sel / 10'd40);
        code_next   = snap_bg_reg[row_idx][col_idx];
        h_pos       = {22'd0, h_cnt};
        v_pos       = {22'd0, v_cnt};
        mario_next  = (h_pos >= snap_mx_reg) && (h_pos < snap_mx_reg + CHARACTER_WIDTH) &&
                      (v_pos >= snap_my_reg) && (v_pos < snap_my_reg + CHARACTER_WIDTH);
        goomba_next = (h_pos >= snap_gx_reg) && (h_pos < snap_gx_reg + CHARACTER_WIDTH) &&
                      (v_pos >= snap_gy_reg) && (v_pos < snap_gy_reg + CHARACTER_WIDTH);
    end

    logic [7:0] s1_code_reg;
    logic       s1_mario_reg;
    logic       s1_goomba_reg;
    logic       s1_visible_reg;
    logic [1:0] hs_dly_reg;
    logic [1:0] vs_dly_reg;

    // Stage 1 registers plus the two-deep sync delay line
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            s1_code_reg    <= BDR;
            s1_mario_reg   <= 1'b0;
            s1_goomba_reg  <= 1'b0;
            s1_visible_reg <= 1'b0;
            hs_dly_reg     <= 2'b11;
            vs_dly_reg     <= 2'b11;
        end else begin
            s1_code_reg    <= code_next;
            s1_mario_reg   <= mario_next;
            s1_goomba_reg  <= goomba_next;
            s1_visible_reg <= visible;
            hs_dly_reg     <= {hs_dly_reg[0], hs_raw};
            vs_dly_reg     <= {vs_dly_reg[0], vs_raw};
        end
    end

`ifdef TILE_GRID_EN
    logic s1_grid_reg;

    // Grid lines sit on the left column and top row of every (scrolled) tile
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            s1_grid_reg <= 1'b0;
        end else begin
            s1_grid_reg <= ((wx % 11'd40) == 11'd0) || ((v_sel % 10'd40) == 10'd0);
        end
    end
`endif

    rgb12_t rgb_next;
    rgb12_t rgb_reg;

    // Stage 2 colour: Mario over Goomba over (grid) over tile palette
    always_comb begin
        rgb_next = BLACK_COLOUR;
        if (s1_visible_reg) begin
            if (s1_mario_reg) begin
                rgb_next = MARIO_COLOUR;
            end else if (s1_goomba_reg) begin
                rgb_next = GOOMBA_COLOUR;
`ifdef TILE_GRID_EN
            end else if (s1_grid_reg) begin
                rgb_next = GRID_COLOUR;
`endif
            end else begin
                rgb_next = tile_colour(s1_code_reg);
            end
        end
    end

    // Stage 2 output register
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            rgb_reg <= BLACK_COLOUR;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign vga_r  = rgb_reg.r;
    assign vga_g  = rgb_reg.g;
    assign vga_b  = rgb_reg.b;
    assign vga_hs = hs_dly_reg[1];
    assign vga_vs = vs_dly_reg[1];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a shrunken raster (same tile, sprite and
// latency rules, short porches) so several frames fit in a short run.
// Every cycle the outputs are compared with a pixel-level model of the frame.
`timescale 1ns/1ps
module tb_vga_tile_renderer;
    import vga_pkg::*;

    localparam int HV  = 160;
    localparam int HF  = 4;
    localparam int HSY = 8;
    localparam int HB  = 4;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VV  = 120;
    localparam int VF  = 2;
    localparam int VSY = 2;
    localparam int VB  = 2;
    localparam int VT  = VV + VF + VSY + VB;

    logic                   vga_clock;
    logic                   reset;
    logic [11:0][16:0][7:0] background;
    logic signed [31:0]     mario_x;
    logic signed [31:0]     mario_y;
    logic signed [31:0]     goomba_x;
    logic signed [31:0]     goomba_y;
    logic [5:0]             scroll_px;
    logic [3:0]             vga_r;
    logic [3:0]             vga_g;
    logic [3:0]             vga_b;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   frame_start;

    vga_tile_renderer #(
        .H_VIS(HV), .H_FP(HF), .H_SW(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SW(VSY), .V_BP(VB)
    ) dut (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .background  (background),
        .mario_x     (mario_x),
        .mario_y     (mario_y),
        .goomba_x    (goomba_x),
        .goomba_y    (goomba_y),
        .scroll_px   (scroll_px),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    initial vga_clock = 1'b0;
    always #20 vga_clock = ~vga_clock;

    int errors = 0;
    int checks = 0;
    int n = 0;

    // Model of what the renderer latched at the last frame snapshot
    logic [7:0] m_bg [12][17];
    longint     m_mx, m_my, m_gx, m_gy;
    int         m_sc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                m_bg[r][c] = BDR;
        m_mx = 1000; m_my = 1000; m_gx = 1000; m_gy = 1000;
        m_sc = 0;
    endtask

    task automatic model_snapshot();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                m_bg[r][c] = background[r][c];
        m_mx = longint'(mario_x);  m_my = longint'(mario_y);
        m_gx = longint'(goomba_x); m_gy = longint'(goomba_y);
        m_sc = (int'(scroll_px) > 39) ? 39 : int'(scroll_px);
    endtask

    function automatic logic [11:0] exp_colour(input int x, input int y);
        int col, row;
        logic [7:0] code;
        if (x >= m_mx && x < m_mx + 42 && y >= m_my && y < m_my + 42) return 12'hF00;
        if (x >= m_gx && x < m_gx + 42 && y >= m_gy && y < m_gy + 42) return 12'h952;
`ifdef TILE_GRID_EN
        if (((x + m_sc) % 40 == 0) || (y % 40 == 0)) return 12'h333;
`endif
        col  = 16 - (x + m_sc) / 40;
        row  = 11 - y / 40;
        code = m_bg[row][col];
        case (code)
            8'd0:    return 12'h000;
            8'd1:    return 12'h58F;
            8'd2:    return 12'h840;
            8'd3:    return 12'h630;
            8'd4:    return 12'hFD0;
            8'd5:    return 12'hFFF;
            8'd6:    return 12'h000;
            default: return 12'hF0F;
        endcase
    endfunction

    // Compare one cycle (outputs show the raster position two cycles back), then advance
    task automatic step();
        int h, v, p, ph, pv;
        logic [11:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        h = n % HT;
        v = (n / HT) % VT;
        e_fs = (h == 0) && (v == VV);
        if (e_fs) model_snapshot();
        p = n - 2;
        if (p < 0) begin
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            ph = p % HT;
            pv = (p / HT) % VT;
            e_hs  = !(ph >= HV + HF && ph < HV + HF + HSY);
            e_vs  = !(pv >= VV + VF && pv < VV + VF + VSY);
            e_rgb = (ph < HV && pv < VV) ? exp_colour(ph, pv) : 12'h000;
        end
        check("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, e_rgb});
        check("hs", 32'(vga_hs), 32'(e_hs));
        check("vs", 32'(vga_vs), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        @(posedge vga_clock);
        n++;
        @(negedge vga_clock);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic random_background();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                background[r][c] = 8'($urandom_range(0, 9));
    endtask

    initial begin
        reset      = 1'b0;
        background = '0;
        mario_x    = 0; mario_y  = 0;
        goomba_x   = 0; goomba_y = 0;
        scroll_px  = '0;
        repeat (3) @(negedge vga_clock);

        // Held in reset: black, syncs idle high, no frame pulse
        check("reset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        check("reset_hs", 32'(vga_hs), 32'd1);
        check("reset_vs", 32'(vga_vs), 32'd1);
        check("reset_frame_start", 32'(frame_start), 32'd0);

        // Frame A: top row sky with brick/ground at the left, scroll 20, overlapping sprites
        random_background();
        for (int c = 0; c < 17; c++) background[11][c] = SKY;
        background[11][16] = BLK;
        background[11][15] = GND;
        background[10][16] = 8'd9;
        scroll_px = 6'd20;
        mario_x   = 100; mario_y  = 50;
        goomba_x  = 120; goomba_y = 70;
        reset = 1'b1;
        model_reset();
        n = 0;
        // Frame 0 is black (reset snapshot); frame A latched at its first blank line
        run(HT * VT + HT * 60);

        // Frame B applied mid-frame: must not show until the next snapshot
        random_background();
        scroll_px = 6'd50;
        mario_x   = -10;
        mario_y   = 32'($urandom_range(0, 70));
        goomba_x  = 1000; goomba_y = 1000;
        run(HT * VT + 50);

        // Asynchronous reset in the middle of a visible line
        reset = 1'b0;
        #1;
        check("midreset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        check("midreset_hs", 32'(vga_hs), 32'd1);
        check("midreset_vs", 32'(vga_vs), 32'd1);
        check("midreset_frame_start", 32'(frame_start), 32'd0);
        @(posedge vga_clock);
        @(negedge vga_clock);
        reset = 1'b1;
        model_reset();
        n = 0;
        // Restarted raster: black picture, sync timing counted from zero again
        run(HT * 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
Consumer side of the screen-drawer interface: takes the 12x17 tile-code map plus sprite positions driven by any screen drawer (game, win, game-over), and scans them out as 640x480@60 VGA.
- Generates its own sync timing.
- Snapshots drawer outputs once per frame so mid-frame drawer updates never tear.
- Colours each pixel via a 2-stage pipeline: tile lookup and sprite hit, then palette.

Parameters:
BDR, 0, tile code: border (black)
SKY, 1, tile code: sky
BLK, 2, tile code: brick block
GND, 3, tile code: ground
TKN, 4, tile code: token/coin
CK1, 5, tile code: checker light
CK2, 6, tile code: checker dark
CHARACTER_WIDTH, 42, sprite box side in pixels
BLOCK_WIDTH, 40, tile side in pixels
SCREEN_WIDTH, 640, visible pixels per line
SCREEN_HEIGHT, 480, visible lines

Ports:
vga_clock  in  1  25.175 MHz pixel clock
reset  in  1  asynchronous, active-low reset
background  in  byte [11:0][16:0]  tile codes; row 11 = top, col 16 = leftmost
mario_x, mario_y  in  int (signed 32)  Mario box top-left, screen pixels
goomba_x, goomba_y  in  int (signed 32)  Goomba box top-left
scroll_px  in  6  horizontal fine scroll, 0..39
vga_r, vga_g, vga_b  out  4 each  pixel colour; 0 when blanked
vga_hs, vga_vs  out  1 each  syncs, active-low
frame_start  out  1  one-cycle pulse when the snapshot is taken

Behaviour:
- Reset (reset=0, async): h_cnt=v_cnt=0, RGB=0, vga_hs=vga_vs=1, frame_start=0, all snapshot tiles=BDR, snapshot sprites=1000 (off-screen), snapshot scroll=0.
- Horizontal timing: h_cnt 0..799.
  - Visible 0..639; front porch 640..655; sync (hs=0) 656..751; back porch 752..799.
- Vertical timing: v_cnt 0..524, advancing when h_cnt wraps 799->0.
  - Visible 0..479; front porch 480..489; sync (vs=0) 490..491; back porch 492..524.
- Snapshot: on the cycle where h_cnt==0 && v_cnt==480, register background, all four sprite coordinates and scroll_px.
  - scroll_px values >39 are clamped to 39.
  - frame_start pulses on the same cycle.
  - Inputs are ignored at all other times.
- Stage 1 (registered), using snapshot values:
  - wx = h_cnt + scroll; col = 16 - wx/40; row = 11 - v_cnt/40.
  - Fetch code = snap[row][col].
  - Mario hit: mario_x <= h_cnt < mario_x+CHARACTER_WIDTH and likewise in y. Signed 32-bit compare, so negative and off-screen values are legal.
  - Goomba hit: same rule. Visible flag = h_cnt<640 && v_cnt<480.
- Stage 2 (registered): colour priority Mario > Goomba > tile palette.
  - Mario F00; Goomba 952.
  - BDR 000, SKY 58F, BLK 840, GND 630, TKN FD0, CK1 FFF, CK2 000; any other code F0F.
  - Not visible -> 000.
- Latency: RGB and syncs both lag the counters by exactly 2 cycles; syncs go through a 2-deep delay line so alignment is exact.
- col range: wx max = 639+39 = 678 gives col 0, so col is always in 0..16 and needs no bound check. row 0..11 is guaranteed in the visible region; outside it, row/col are don't-care and masked by visible.
- Reset mid-frame: everything returns to reset values immediately; the next snapshot occurs at v_cnt==480 of the restarted frame, and the screen is all black until then.

Optional Feature:
TILE_GRID_EN
- Defined: pixels with wx%40==0 or v_cnt%40==0 that are not covered by a sprite render 333 (grid overlay for level debugging).
- Undefined: no overlay, and no extra logic synthesised.

Decomposition:
- Package vga_pkg holds:
  - tile code localparams;
  - H/V timing constants (visible, front porch, sync, back porch, total);
  - typedef rgb12_t (struct of three 4-bit channels);
  - palette function tile_colour(code) -> rgb12_t.
- Natural sub-module: vga_timing_gen, providing h_cnt, v_cnt, raw hs/vs, visible and snapshot strobe; the renderer wraps it with the snapshot and pipeline.

Test Plan:
- Reset, then run 800*525 cycles -> exactly one hs low of 96 cycles per line, vs low for 2 lines (1600 cycles), frame_start once per frame at h=0,v=480.
- All tiles SKY except snap[11][16]=BLK, scroll 0 -> pixel (0,0)..(39,39) = 840, (40,0) = 58F, RGB appearing 2 cycles after the counters.
- scroll_px=20, background col 16 = BLK, col 15 = GND -> line 0 pixels 0..19 = 840, pixels 20..59 = 630; scroll_px=50 behaves as 39.
- mario=(100,100), goomba=(120,120) -> (130,130) = F00, (150,150) = 952, (99,100) = tile colour; mario_x=-10 -> columns 0..31 red; coordinates 1000 -> no sprite.
- Change background and mario_x at v_cnt=200 -> frame unchanged until the v_cnt=480 snapshot, new values in the next frame.
- Tile code 9 -> F0F; assert reset at v_cnt=300 -> RGB=0 and hs=vs=1 immediately, counters restart at 0.
